// File: rtl/keyboard_fifo.sv
// PS/2 keyboard receiver with glitch filter, make/break/extended decode and event FIFO.
// Latency: event pushed the cycle after the stop-bit edge; out_valid rises one cycle later.
// Backpressure: out_ready low holds the head; a push into a full FIFO without a pop is dropped and flagged.
//
// Ports:
//   clk, rst_n            system clock, synchronous active-low reset
//   key_clk, key_data     raw PS/2 lines (asynchronous)
//   out_valid/out_ready   FIFO head handshake (first-word fall-through)
//   keycode, key_status   head scancode; {4'b0, parity_err, overflow, extended, is_break}
//   clr_err               clears sticky parity_err/overflow
// Optional feature: define KEYBOARD_PARITY_CHECK_EN to discard bad-parity bytes and flag them.

module keyboard_fifo #(
  parameter int DEPTH      = 16,
  parameter int FILTER_LEN = 8,
  parameter int TIMEOUT    = 5000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       key_clk,
  input  logic       key_data,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] keycode,
  output logic [7:0] key_status,
  input  logic       clr_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int FW = $clog2(FILTER_LEN + 1);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [FW-1:0] FILT_LAST = FW'(FILTER_LEN - 1);
  localparam logic [TW-1:0] TMO_LAST  = TW'(TIMEOUT - 1);
  localparam logic [AW:0]   FULL_CNT  = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} rx_state_t;

  // Two-flop synchronizers; idle PS/2 lines are high, so reset to 1.
  logic kc_meta_q, kc_sync_q, kd_meta_q, kd_sync_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      kc_meta_q <= 1'b1;
      kc_sync_q <= 1'b1;
      kd_meta_q <= 1'b1;
      kd_sync_q <= 1'b1;
    end else begin
      kc_meta_q <= key_clk;
      kc_sync_q <= kc_meta_q;
      kd_meta_q <= key_data;
      kd_sync_q <= kd_meta_q;
    end
  end

  // Glitch filter: the filtered level flips on the FILTER_LEN-th consecutive
  // synchronized sample that disagrees with it.
  logic          filt_q;
  logic [FW-1:0] fcnt_q;
  logic          filt_flip;
  logic          fall;

  assign filt_flip = (kc_sync_q != filt_q) && (fcnt_q == FILT_LAST);
  assign fall      = filt_flip && filt_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      filt_q <= 1'b1;
      fcnt_q <= '0;
    end else if (kc_sync_q == filt_q) begin
      fcnt_q <= '0;
    end else if (filt_flip) begin
      filt_q <= kc_sync_q;
      fcnt_q <= '0;
    end else begin
      fcnt_q <= fcnt_q + FW'(1);
    end
  end

  // Receiver FSM
  rx_state_t     state_q, state_d;
  logic [2:0]    bitcnt_q;
  logic [7:0]    shift_q;
  logic [TW-1:0] tmo_q;
  logic          par_ok;
  logic          frame_ok;
  logic          perr_set;

`ifdef KEYBOARD_PARITY_CHECK_EN
  logic par_q;
  // Odd parity: data bits plus parity bit must contain an odd number of ones.
  assign par_ok = ^{shift_q, par_q};
`else
  assign par_ok = 1'b1;
`endif

  always_comb begin
    state_d  = state_q;
    frame_ok = 1'b0;
    perr_set = 1'b0;
    case (state_q)
      IDLE:   if (fall && !kd_sync_q) state_d = DATA;
      DATA:   if (fall && bitcnt_q == 3'd7) state_d = PARITY;
      PARITY: if (fall) state_d = STOP;
      STOP: begin
        if (fall) begin
          state_d = IDLE;
          // A bad stop bit drops the frame silently.
          if (kd_sync_q) begin
            frame_ok = par_ok;
            perr_set = !par_ok;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    // Stalled partial frame: give up and wait for a fresh start bit.
    if (state_q != IDLE && !fall && tmo_q == TMO_LAST) state_d = IDLE;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      bitcnt_q <= '0;
      shift_q  <= '0;
      tmo_q    <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE || fall) tmo_q <= '0;
      else if (tmo_q != TMO_LAST) tmo_q <= tmo_q + TW'(1);
      if (state_q == IDLE) bitcnt_q <= '0;
      if (state_q == DATA && fall) begin
        shift_q  <= {kd_sync_q, shift_q[7:1]};
        bitcnt_q <= bitcnt_q + 3'd1;
      end
    end
  end

`ifdef KEYBOARD_PARITY_CHECK_EN
  always_ff @(posedge clk) begin
    if (!rst_n) par_q <= 1'b0;
    else if (state_q == PARITY && fall) par_q <= kd_sync_q;
  end
`endif

  // Byte decode, one cycle after the stop edge
  logic       byte_vld_q;
  logic [7:0] byte_q;
  logic       brk_pend_q, ext_pend_q;
  logic       is_f0, is_e0, push;
  logic [9:0] push_dat;

  assign is_f0    = (byte_q == 8'hF0);
  assign is_e0    = (byte_q == 8'hE0);
  assign push     = byte_vld_q && !is_f0 && !is_e0;
  assign push_dat = {ext_pend_q, brk_pend_q, byte_q};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      byte_vld_q <= 1'b0;
      byte_q     <= '0;
      brk_pend_q <= 1'b0;
      ext_pend_q <= 1'b0;
    end else begin
      byte_vld_q <= frame_ok;
      if (frame_ok) byte_q <= shift_q;
      if (byte_vld_q) begin
        if (is_f0) brk_pend_q <= 1'b1;
        else if (is_e0) ext_pend_q <= 1'b1;
        else begin
          brk_pend_q <= 1'b0;
          ext_pend_q <= 1'b0;
        end
      end
    end
  end

  // Event FIFO, first-word fall-through
  logic [9:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [AW:0]   cnt_q;
  logic          full, pop, wr_en, ovf_set;
  logic [9:0]    head;

  assign full      = (cnt_q == FULL_CNT);
  assign out_valid = (cnt_q != '0);
  assign pop       = out_valid && out_ready;
  // Full FIFO still accepts a push when the head leaves in the same cycle.
  assign wr_en     = push && (!full || pop);
  assign ovf_set   = push && full && !pop;
  assign head      = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_ptr_q] <= push_dat;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)   rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr_en, pop})
        2'b10:   cnt_q <= cnt_q + (AW + 1)'(1);
        2'b01:   cnt_q <= cnt_q - (AW + 1)'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Sticky error flags; a new error wins over a simultaneous clear.
  logic ovf_q;
  logic perr_bit;

  always_ff @(posedge clk) begin
    if (!rst_n) ovf_q <= 1'b0;
    else if (ovf_set) ovf_q <= 1'b1;
    else if (clr_err) ovf_q <= 1'b0;
  end

`ifdef KEYBOARD_PARITY_CHECK_EN
  logic perr_q;
  always_ff @(posedge clk) begin
    if (!rst_n) perr_q <= 1'b0;
    else if (perr_set) perr_q <= 1'b1;
    else if (clr_err) perr_q <= 1'b0;
  end
  assign perr_bit = perr_q;
`else
  logic unused_perr;
  assign unused_perr = perr_set;
  assign perr_bit    = 1'b0;
`endif

  assign keycode    = out_valid ? head[7:0] : 8'h00;
  assign key_status = {4'b0000, perr_bit, ovf_q, (out_valid ? head[9:8] : 2'b00)};

endmodule

// File: doc/keyboard_fifo.md
KEYBOARD_FIFO -- requirements
Module: keyboard_fifo

Interface
REQ-001 Parameter DEPTH, default 16, scan-event FIFO entries; power of two, >= 2.
REQ-002 Parameter FILTER_LEN, default 8, consecutive clk samples needed to accept a key_clk level change.
REQ-003 Parameter TIMEOUT, default 5000, clk cycles without key_clk falling edge before a partial frame is aborted.
REQ-004 clk  input  1  system clock; all logic on rising edge.
REQ-005 rst_n  input  1  synchronous, active-low reset.
REQ-006 key_clk  input  1  PS/2 clock, asynchronous to clk.
REQ-007 key_data  input  1  PS/2 data, asynchronous to clk.
REQ-008 out_valid  output  1  FIFO head holds an event.
REQ-009 out_ready  input  1  consumer pops head when high with out_valid.
REQ-010 keycode  output  8  scancode of FIFO head.
REQ-011 key_status  output  8  {4'b0, parity_err, overflow, extended, is_break}; bits 1:0 from head, bits 3:2 sticky.
REQ-012 clr_err  input  1  clears sticky bits key_status[3:2].

Function
REQ-013 key_clk, key_data SHALL pass a 2-flop synchronizer; filtered key_clk changes only after FILTER_LEN equal synchronized samples.
REQ-014 Frame bits SHALL be sampled on filtered key_clk falling edges: start(0), 8 data LSB-first, odd parity, stop(1).
REQ-015 Receiver FSM states IDLE, DATA, PARITY, STOP; IDLE->DATA on edge with data=0 (edge with data=1 ignored); DATA->PARITY after 8th bit; PARITY->STOP; STOP->IDLE on next edge.
REQ-016 Stop bit 0 SHALL discard the frame, no flag set.
REQ-017 TIMEOUT cycles with no falling edge outside IDLE SHALL return FSM to IDLE, discarding partial byte.
REQ-018 Byte 0xF0 SHALL set a pending break flag, 0xE0 a pending extended flag; neither pushes an event.
REQ-019 Other bytes SHALL push {extended, is_break, keycode} into FIFO, then clear both pending flags.
REQ-020 Push SHALL occur the clk cycle after the stop-bit edge is processed; out_valid rises the cycle after push into empty FIFO.
REQ-021 FIFO first-word-fall-through: keycode/key_status[1:0] show head whenever out_valid=1; hold value while out_valid=1 and out_ready=0.
REQ-022 Pop on out_valid & out_ready; next entry visible following cycle.
REQ-023 Push when full and no pop: event dropped, overflow set; push and pop same cycle when full: both performed, no overflow.
REQ-024 Pointers wrap modulo DEPTH; occupancy counter log2(DEPTH)+1 bits.
REQ-025 clr_err clears sticky bits next cycle; a set event in same cycle wins.
REQ-026 out_valid=0 SHALL force keycode=0x00 and key_status[1:0]=0.

Reset
REQ-027 rst_n=0 at rising clk SHALL: FSM to IDLE, FIFO empty, pending flags and sticky bits cleared, filter state to 1, out_valid=0, keycode=0x00, key_status=0x00.
REQ-028 Reset mid-frame SHALL discard the partial frame; reception resumes on the next start bit after release.

Configuration
REQ-029 Macro KEYBOARD_PARITY_CHECK_EN defined: parity mismatch discards byte and sets key_status[3].
REQ-030 Macro undefined: parity bit sampled but ignored, byte accepted, key_status[3] constant 0.

Verification
REQ-031 Frame 0x1C, correct parity, FIFO empty -> out_valid=1, keycode=0x1C, key_status=0x00.
REQ-032 Frames F0,1C -> one event keycode=0x1C, key_status=0x01; frames E0,F0,75 -> keycode=0x75, key_status=0x03.
REQ-033 DEPTH=4, out_ready=0, 5 frames 0x15..0x19 -> head 0x15, key_status[2]=1; popping yields 0x15,0x16,0x17,0x18 then out_valid=0.
REQ-034 Frame 0x1C with bad parity, macro defined -> no event, key_status=0x08; clr_err pulse -> 0x00; macro undefined -> event 0x1C, key_status=0x00.
REQ-035 Start + 4 data bits then idle TIMEOUT+10 cycles, then full frame 0x2A -> exactly one event keycode=0x2A.
REQ-036 rst_n low 1 cycle after 5th data edge, then frame 0x33 -> only event 0x33, sticky bits 0.
